// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver for the pixel link.
// Receives LSB-first frames, rejects false start bits, flags framing errors and tags each
// completed word with a wrapping pixel address plus a frame-start pulse at address 0.
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit after the data bits and makes
// parity_err live; without it frames are DnN and parity_err is constant 0.
module uart_rx_frame #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned ADDR_MAX   = 76800,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              s_tick,
  input  logic              addr_clr,
  output logic              rx_done_tick,
  output logic [DBIT-1:0]   dout,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_start,
  output logic              frame_err,
  output logic              parity_err
);

  // Elaboration-time legality checks on the configuration.
  if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
    $error("uart_rx_frame: DBIT must be 5..9");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_frame: OVERSAMPLE must be even, 8..32");
  end
  if (SB_TICK < OVERSAMPLE) begin : g_bad_sb
    $error("uart_rx_frame: SB_TICK must cover at least one stop bit");
  end
  if (PARITY_ODD > 1) begin : g_bad_par
    $error("uart_rx_frame: PARITY_ODD must be 0 or 1");
  end

  localparam int unsigned SMax = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned SW   = $clog2(SMax);
  localparam int unsigned NW   = $clog2(DBIT);

  localparam logic [SW-1:0]     SHalfLast = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]     SBitLast  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0]     SStopLast = SW'(SB_TICK - 1);
  localparam logic [NW-1:0]     NLast     = NW'(DBIT - 1);
  localparam logic [ADDR_W-1:0] AddrLast  = ADDR_W'(ADDR_MAX - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e              state_q;
  logic [SW-1:0]       s_q;
  logic [NW-1:0]       n_q;
  logic [DBIT-1:0]     b_q;
  logic                ferr_q;
  logic                rx_meta_q, rx_s_q;
  logic [ADDR_W-1:0]   addr_cnt_q;
  logic                done_q, fs_q, fe_q;
  logic [DBIT-1:0]     dout_q;
  logic [ADDR_W-1:0]   addr_q;

  logic [ADDR_W-1:0]   addr_base, addr_inc;
  logic                fe_now;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Address for a word completing now (addr_clr wins) and the counter value after it.
  always_comb begin
    addr_base = addr_clr ? '0 : addr_cnt_q;
    addr_inc  = (addr_base == AddrLast) ? '0 : addr_base + ADDR_W'(1);
    // The stop sample and the final stop tick coincide when SB_TICK == OVERSAMPLE.
    fe_now    = ferr_q | ((s_q == SBitLast) & ~rx_s_q);
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q, pe_q;
`endif

  // Receive FSM, address counter and registered word outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      ferr_q     <= 1'b0;
      addr_cnt_q <= '0;
      done_q     <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      dout_q     <= '0;
      addr_q     <= '0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      fs_q   <= 1'b0;
      // A completing word below overrides this with its own counter update.
      if (addr_clr) begin
        addr_cnt_q <= '0;
      end
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q <= StStart;
            s_q     <= '0;
          end
        end
        StStart: begin
          if (s_tick) begin
            if (s_q == SHalfLast) begin
              if (rx_s_q) begin
                state_q <= StIdle;  // line back high at mid start bit: glitch
              end else begin
                state_q <= StData;
                s_q     <= '0;
                n_q     <= '0;
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        StData: begin
          if (s_tick) begin
            if (s_q == SBitLast) begin
              s_q <= '0;
              b_q <= {rx_s_q, b_q[DBIT-1:1]};
              if (n_q == NLast) begin
`ifdef UART_RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
                ferr_q  <= 1'b0;
`endif
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (s_tick) begin
            if (s_q == SBitLast) begin
              s_q     <= '0;
              perr_q  <= (^{b_q, rx_s_q}) != PARITY_ODD[0];
              ferr_q  <= 1'b0;
              state_q <= StStop;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
`endif
        StStop: begin
          if (s_tick) begin
            if ((s_q == SBitLast) && !rx_s_q) begin
              ferr_q <= 1'b1;
            end
            if (s_q == SStopLast) begin
              state_q    <= StIdle;
              s_q        <= '0;
              done_q     <= 1'b1;
              fs_q       <= (addr_base == '0);
              dout_q     <= b_q;
              addr_q     <= addr_base;
              addr_cnt_q <= addr_inc;
              fe_q       <= fe_now;
`ifdef UART_RX_PARITY_EN
              pe_q       <= perr_q;
`endif
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_done_tick = done_q;
  assign frame_start  = fs_q;
  assign frame_err    = fe_q;
  assign dout         = dout_q;
  assign addr         = addr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = pe_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: a default-address instance and a small wrapping instance with a
// 1.5-bit stop period share one serial line. Expected words come from frame-level rules.
module tb_uart_rx_frame;

  localparam int unsigned AddrMaxM = 76800;
  localparam int unsigned AddrMaxW = 4;
  localparam int unsigned BitClk   = 64;  // 16 ticks x 4 clk
`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, s_tick = 1'b0, addr_clr = 1'b0;

  logic        done_m, fs_m, fe_m, pe_m;
  logic [7:0]  dout_m;
  logic [16:0] addr_m;
  logic        done_w, fs_w, fe_w, pe_w;
  logic [7:0]  dout_w;
  logic [1:0]  addr_w;

  uart_rx_frame #(
    .DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .ADDR_W(17), .ADDR_MAX(AddrMaxM), .PARITY_ODD(0)
  ) u_dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .addr_clr(addr_clr),
    .rx_done_tick(done_m), .dout(dout_m), .addr(addr_m), .frame_start(fs_m),
    .frame_err(fe_m), .parity_err(pe_m)
  );

  uart_rx_frame #(
    .DBIT(8), .OVERSAMPLE(16), .SB_TICK(24), .ADDR_W(2), .ADDR_MAX(AddrMaxW), .PARITY_ODD(0)
  ) u_wrap (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .addr_clr(addr_clr),
    .rx_done_tick(done_w), .dout(dout_w), .addr(addr_w), .frame_start(fs_w),
    .frame_err(fe_w), .parity_err(pe_w)
  );

  always #5 clk = ~clk;

  // Baud generator: one s_tick every 4 clk.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      s_tick = (cnt == 3);
      cnt = (cnt + 1) % 4;
    end
  end

  typedef struct {
    logic [7:0]  dout;
    logic [16:0] addr;
    logic        fe, pe, fs;
  } word_t;

  word_t q_m[$], q_w[$];
  word_t cap_m, cap_w;

  // Capture every completed word from both instances.
  always @(negedge clk) begin
    if (done_m) begin
      cap_m.dout = dout_m; cap_m.addr = addr_m; cap_m.fe = fe_m; cap_m.pe = pe_m; cap_m.fs = fs_m;
      q_m.push_back(cap_m);
    end
    if (done_w) begin
      cap_w.dout = dout_w; cap_w.addr = 17'(addr_w); cap_w.fe = fe_w; cap_w.pe = pe_w;
      cap_w.fs = fs_w;
      q_w.push_back(cap_w);
    end
  end

  int checks = 0, failures = 0;
  int am = 0, aw = 0;  // model: address of the next completed word per instance

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    rx = 1'b0;
    wait_clk(BitClk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BitClk);
    end
    if (ParEn) begin
      rx = (^d) ^ ~par_ok;  // even parity, inverted for a bad-parity frame
      wait_clk(BitClk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_clk(2 * BitClk);
    end else begin
      rx = 1'b0;  // low through the stop sample point, then back high
      wait_clk(48);
      rx = 1'b1;
      wait_clk(2 * BitClk - 48);
    end
    wait_clk(40);
  endtask

  task automatic glitch();
    rx = 1'b0;
    wait_clk(20);  // 5 s_ticks, well short of half a bit
    rx = 1'b1;
    wait_clk(100);
  endtask

  task automatic pulse_clr();
    addr_clr = 1'b1;
    wait_clk(1);
    addr_clr = 1'b0;
    am = 0;
    aw = 0;
  endtask

  // Compare the single expected word on each instance.
  task automatic check_word(input string tag, input logic [7:0] d, input int ea_m,
                            input int ea_w, input bit fe, input bit pe);
    word_t w;
    chk({tag, " count_m"}, 32'(q_m.size()), 32'd1);
    if (q_m.size() > 0) begin
      w = q_m.pop_front();
      chk({tag, " dout_m"}, 32'(w.dout), 32'(d));
      chk({tag, " addr_m"}, 32'(w.addr), 32'(ea_m));
      chk({tag, " ferr_m"}, 32'(w.fe), 32'(fe));
      chk({tag, " perr_m"}, 32'(w.pe), 32'(pe));
      chk({tag, " fstart_m"}, 32'(w.fs), 32'(ea_m == 0));
    end
    chk({tag, " count_w"}, 32'(q_w.size()), 32'd1);
    if (q_w.size() > 0) begin
      w = q_w.pop_front();
      chk({tag, " dout_w"}, 32'(w.dout), 32'(d));
      chk({tag, " addr_w"}, 32'(w.addr), 32'(ea_w));
      chk({tag, " ferr_w"}, 32'(w.fe), 32'(fe));
      chk({tag, " perr_w"}, 32'(w.pe), 32'(pe));
      chk({tag, " fstart_w"}, 32'(w.fs), 32'(ea_w == 0));
    end
    q_m.delete();
    q_w.delete();
  endtask

  // Model-driven word: expectations from the running address model.
  task automatic model_word(input string tag, input logic [7:0] d, input bit stop_ok,
                            input bit par_ok);
    int ea_m, ea_w;
    ea_m = am;
    ea_w = aw;
    am = (am + 1) % AddrMaxM;
    aw = (aw + 1) % AddrMaxW;
    send_frame(d, stop_ok, par_ok);
    check_word(tag, d, ea_m, ea_w, ~stop_ok, ParEn & ~par_ok);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         par_ok;
    bit         glitch_first;
    int         exp_am;
    int         exp_aw;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1, 1};
    vecs[2] = '{8'h81, 1'b0, 1'b1, 1'b0, 2, 2};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b0, 3, 3};
    vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b0, 4, 0};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b0, 5, 1};

    wait_clk(5);
    chk("reset done_m", 32'(done_m), 32'd0);
    chk("reset dout_m", 32'(dout_m), 32'd0);
    chk("reset addr_m", 32'(addr_m), 32'd0);
    chk("reset flags_m", {29'd0, fs_m, fe_m, pe_m}, 32'd0);
    reset = 1'b0;
    wait_clk(10);

    // Directed table: glitch rejection, framing error, parity, address wrap.
    foreach (vecs[i]) begin
      if (vecs[i].glitch_first) glitch();
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].par_ok);
      check_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_am, vecs[i].exp_aw,
                 ~vecs[i].stop_ok, ParEn & ~vecs[i].par_ok);
    end
    am = 6;
    aw = 2;

    // addr_clr restarts addressing on both instances.
    pulse_clr();
    model_word("clr0", 8'h11, 1'b1, 1'b1);
    model_word("clr1", 8'h22, 1'b1, 1'b1);

    // Reset in the middle of the data bits: no word, then clean restart at address 0.
    rx = 1'b0;
    wait_clk(BitClk * 4);
    reset = 1'b1;
    rx = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    am = 0;
    aw = 0;
    wait_clk(800);
    chk("midreset no_done_m", 32'(q_m.size()), 32'd0);
    chk("midreset no_done_w", 32'(q_w.size()), 32'd0);
    chk("midreset addr_m", 32'(addr_m), 32'd0);
    q_m.delete();
    q_w.delete();
    model_word("post_reset", 8'h3C, 1'b1, 1'b1);

    // Randomised words against the model.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      bit sok, pok;
      d   = 8'($urandom);
      sok = ($urandom_range(0, 3) != 0);
      pok = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) pulse_clr();
      if ($urandom_range(0, 4) == 0) glitch();
      model_word($sformatf("rand%0d", i), d, sok, pok);
    end

    wait_clk(200);
    chk("stray_m", 32'(q_m.size()), 32'd0);
    chk("stray_w", 32'(q_w.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver for the camera/pixel link into the ball-locator datapath. It deserialises LSB-first frames with configurable data width, oversampling and stop length. It rejects false start bits and reports framing errors, plus parity errors when parity is compiled in. Each received word is tagged with a wrapping pixel address, and a frame-start pulse is issued at address 0 so the downstream frame buffer can resynchronise.

## Interface
Parameters:
- DBIT, 8: data bits per frame, legal 5..9.
- OVERSAMPLE, 16: s_tick pulses per bit time, even, 8..32.
- SB_TICK, 16: s_tick pulses for the stop period. OVERSAMPLE = 1 stop bit; 1.5×OVERSAMPLE = 1.5 bits; 2×OVERSAMPLE = 2 bits.
- ADDR_W, 17: address width.
- ADDR_MAX, 76800: words per frame (320×240); address wraps from ADDR_MAX-1 to 0.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only when parity is compiled in.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idles high.
- s_tick  in  1  one-clk oversample strobe from the baud generator.
- addr_clr  in  1  synchronous request to restart addressing at 0.
- rx_done_tick  out  1  one-clk pulse; word, address and error flags are valid in this cycle.
- dout  out  DBIT  last received word, held until the next rx_done_tick.
- addr  out  ADDR_W  address of the word on dout, held.
- frame_start  out  1  one-clk pulse, coincident with rx_done_tick, when addr == 0.
- frame_err  out  1  stop bit sampled low for the word on dout, held.
- parity_err  out  1  parity mismatch for the word on dout, held. Tied 0 when parity is compiled out.

## Operation
- rx passes through a 2-FF synchroniser (rx_s). All sampling uses rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP. s counter holds 0..max(OVERSAMPLE, SB_TICK)-1. n counter counts data bits.
- IDLE: rx_s == 0 → START, s = 0.
- START: counts s_tick. At s == OVERSAMPLE/2-1:
  - rx_s == 1 → false start; return to IDLE with no output activity.
  - otherwise → DATA, s = 0, n = 0.
- DATA: on each s_tick at s == OVERSAMPLE-1, sample at bit centre. Shift right, new bit into MSB (LSB first). After bit DBIT-1 → PARITY (if compiled in), else → STOP.
- PARITY: sample at s == OVERSAMPLE-1. Mismatch: XOR of data and parity bit ≠ PARITY_ODD.
- STOP: sample rx_s at s == OVERSAMPLE-1; 0 sets frame_err. At s == SB_TICK-1 → IDLE and complete the word.
- Word completion: dout, addr, frame_err and parity_err load together; rx_done_tick pulses. Errored words still complete and consume an address, so the pixel count stays aligned.
- Address counter: increments by 1 per completed word; wraps from ADDR_MAX-1 to 0.
- addr_clr: the next completed word gets address 0, including a word completing in the same cycle. Has priority over the increment.
- s_tick absent: the FSM holds state. Counters advance only on s_tick.

## Timing
- Reset values: rx_done_tick, frame_start, frame_err, parity_err = 0; dout = 0; addr = 0; address counter = 0; FSM in IDLE; synchroniser = 1.
- reset mid-frame: the next clk is IDLE, the partial word is discarded, and no done pulse is issued.
- rx falling edge to START: 2–3 clk (synchroniser).
- rx_done_tick: registered, asserted for exactly one clk, in the clk after the final STOP s_tick. Outputs are stable from that cycle until the next done pulse.
- Frame length: OVERSAMPLE/2 + (DBIT [+1 if parity]) × OVERSAMPLE + SB_TICK s_ticks from START entry to done.
- A new start bit is accepted the clk after STOP completes.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state exists, one parity bit is expected after data, and parity_err is live.
- UART_RX_PARITY_EN undefined: no PARITY state, frames are DnN, and parity_err is constant 0.

## Test plan
- 8N1, OVERSAMPLE=16, s_tick every 4 clk; send 0xA5 → one rx_done_tick, dout=0xA5, addr=0, frame_start=1, frame_err=0.
- 5-tick low glitch on rx → no rx_done_tick; a following 0x3C is received correctly with addr=0.
- Send 0x81 with stop bit held low → rx_done_tick, dout=0x81, frame_err=1. The next good word clears frame_err and gets addr=1.
- UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity 1 → parity_err=0; with parity 0 → parity_err=1.
- ADDR_MAX=4: send 6 words → addr sequence 0,1,2,3,0,1; frame_start on the 1st and 5th words.
- Pulse addr_clr after word 2, then assert reset mid-data of word 3 → no done pulse; next word has addr=0 and all flags 0.
